// File: rtl/gate_share_pkg.sv
// Shared opcode and FSM state definitions for gate_share_arbiter and its arbiter.
package gate_share_pkg;

    localparam logic [1:0] OP_NAND = 2'b00;
    localparam logic [1:0] OP_AND  = 2'b01;
    localparam logic [1:0] OP_OR   = 2'b10;
    localparam logic [1:0] OP_XOR  = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after last_grant_i, wrapping at N_REQ.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [ID_W-1:0]  last_grant_i,
    input  logic             en_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]  gnt_idx_o,
    output logic             any_gnt_o
);

    logic [ID_W-1:0] idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_gnt_o = 1'b0;
        idx       = '0;
        // k runs 1..N_REQ so the previous winner is searched last
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(last_grant_i) + k) % N_REQ);
            if (en_i && !any_gnt_o && req_i[idx]) begin
                any_gnt_o  = 1'b1;
                gnt_idx_o  = idx;
                gnt_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gate_share_arbiter.sv
// Round-robin shared registered bitwise unit (NAND by default).
// Define GATE_SHARE_OPSEL_EN to add per-request opcode select (req_op/rsp_op).
module gate_share_arbiter
    import gate_share_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 3,
    parameter int ID_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    output logic [ID_W-1:0]        rsp_id,
    output logic [WIDTH-1:0]       rsp_data,
    input  logic                   rsp_ready,
    output logic                   busy
`ifdef GATE_SHARE_OPSEL_EN
    ,
    input  logic [N_REQ*2-1:0]     req_op,
    output logic [1:0]             rsp_op
`endif
);

    state_e           state_q, state_d;
    logic [ID_W-1:0]  last_q, last_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] a_g, b_g, res;
    logic [1:0]       op_g;
    logic             can_accept;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic             any_gnt;

    // A held result may be replaced in the same cycle it is consumed
    assign can_accept = (state_q == ST_IDLE) || rsp_ready;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req_i        (req_valid),
        .last_grant_i (last_q),
        .en_i         (can_accept),
        .gnt_o        (gnt),
        .gnt_idx_o    (gnt_idx),
        .any_gnt_o    (any_gnt)
    );

    assign req_ready = gnt;

    always_comb begin
        a_g  = '0;
        b_g  = '0;
        op_g = OP_NAND;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                a_g = req_a[i*WIDTH +: WIDTH];
                b_g = req_b[i*WIDTH +: WIDTH];
`ifdef GATE_SHARE_OPSEL_EN
                op_g = req_op[i*2 +: 2];
`endif
            end
        end
    end

    always_comb begin
        case (op_g)
            OP_AND:  res = a_g & b_g;
            OP_OR:   res = a_g | b_g;
            OP_XOR:  res = a_g ^ b_g;
            default: res = ~(a_g & b_g);
        endcase
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        data_d  = data_q;
        if (any_gnt) begin
            state_d = ST_HOLD;
            last_d  = gnt_idx;
            id_d    = gnt_idx;
            data_d  = res;
        end else if (state_q == ST_HOLD && rsp_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= ID_W'(N_REQ - 1);
            id_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            data_q  <= data_d;
        end
    end

`ifdef GATE_SHARE_OPSEL_EN
    logic [1:0] op_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       op_q <= OP_NAND;
        else if (any_gnt) op_q <= op_g;
    end

    assign rsp_op = op_q;
`endif

    assign rsp_valid = (state_q == ST_HOLD);
    assign busy      = (state_q == ST_HOLD);
    assign rsp_id    = id_q;
    assign rsp_data  = data_q;

endmodule

// File: tb/tb_gate_share_arbiter.sv
// Randomized + directed bench for gate_share_arbiter against a queue-free behavioural model.
module tb_gate_share_arbiter;

    localparam int N = 4;
    localparam int W = 3;
    localparam int IW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   tb_v = '0;
    logic [N*W-1:0] tb_a = '0;
    logic [N*W-1:0] tb_b = '0;
    logic [N*2-1:0] tb_op = '0;
    logic           tb_rr = 1'b0;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [IW-1:0]  rsp_id;
    logic [W-1:0]   rsp_data;
    logic           busy;
    logic [1:0]     rsp_op;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model state: what the block holds after the most recent edge
    int         m_last;
    bit         m_held;
    logic [W-1:0] m_data;
    int         m_id;
    logic [1:0] m_op;
    logic [N-1:0] act_ready;

`ifdef GATE_SHARE_OPSEL_EN
    localparam bit OPSEL = 1'b1;
    gate_share_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(tb_v), .req_a(tb_a), .req_b(tb_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_ready(tb_rr), .busy(busy),
        .req_op(tb_op), .rsp_op(rsp_op));
`else
    localparam bit OPSEL = 1'b0;
    assign rsp_op = 2'b00;
    gate_share_arbiter #(.N_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(tb_v), .req_a(tb_a), .req_b(tb_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_ready(tb_rr), .busy(busy));
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        if (!OPSEL) return ~(a & b);
        case (op)
            2'b01:   return a & b;
            2'b10:   return a | b;
            2'b11:   return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    task automatic model_reset();
        m_last = N - 1;
        m_held = 1'b0;
        m_data = '0;
        m_id   = 0;
        m_op   = 2'b00;
    endtask

    // Called just after inputs change: compare, then advance model to the next edge
    task automatic step();
        int g;
        logic [N-1:0] exp_ready;
        #1;
        g = -1;
        exp_ready = '0;
        if (!m_held || tb_rr)
            for (int k = 1; k <= N; k++)
                if (g < 0 && tb_v[(m_last + k) % N]) g = (m_last + k) % N;
        if (g >= 0) exp_ready[g] = 1'b1;
        act_ready = req_ready;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_held));
        chk("busy", 32'(busy), 32'(m_held));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_data", 32'(rsp_data), 32'(m_data));
        if (OPSEL) chk("rsp_op", 32'(rsp_op), 32'(m_op));
        if (g >= 0) begin
            m_op   = OPSEL ? tb_op[g*2 +: 2] : 2'b00;
            m_data = ref_op(m_op, tb_a[g*W +: W], tb_b[g*W +: W]);
            m_id   = g;
            m_last = g;
            m_held = 1'b1;
        end else if (m_held && tb_rr) begin
            m_held = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        tb_v  = '0;
        tb_rr = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_data", 32'(rsp_data), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int exp_seq[5] = '{0, 1, 2, 3, 0};
    logic [1:0] ops[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [W-1:0] op_res[4] = '{3'b101, 3'b010, 3'b111, 3'b101};

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // single request, NAND 111 & 101
        tb_v = 4'b0001; tb_a[0 +: W] = 3'b111; tb_b[0 +: W] = 3'b101; tb_rr = 1'b1;
        step();
        chk("t1_ready", 32'(act_ready), 32'b0001);
        chk("t1_valid", 32'(rsp_valid), 32'd1);
        chk("t1_id", 32'(rsp_id), 32'd0);
        chk("t1_data", 32'(rsp_data), 32'b010);
        tb_v = '0;
        step();
        chk("t1_idle", 32'(rsp_valid), 32'd0);

        // fairness with all requesters valid
        do_reset();
        tb_v = 4'b1111; tb_rr = 1'b1;
        for (int i = 0; i < N; i++) begin
            tb_a[i*W +: W] = 3'b000;
            tb_b[i*W +: W] = 3'b010;
        end
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t2_ready", 32'(act_ready), 32'(1) << exp_seq[k]);
            chk("t2_id", 32'(rsp_id), 32'(exp_seq[k]));
            chk("t2_data", 32'(rsp_data), 32'b111);
        end

        // backpressure holds the result
        do_reset();
        tb_v = 4'b0100; tb_a[2*W +: W] = 3'b001; tb_b[2*W +: W] = 3'b011; tb_rr = 1'b0;
        step();
        chk("t3_first", 32'(act_ready), 32'b0100);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t3_ready", 32'(act_ready), 32'd0);
            chk("t3_valid", 32'(rsp_valid), 32'd1);
            chk("t3_id", 32'(rsp_id), 32'd2);
            chk("t3_data", 32'(rsp_data), 32'b110);
        end
        tb_rr = 1'b1;
        step();
        chk("t3_regrant", 32'(act_ready), 32'b0100);

        // wrap-around after last_grant=1
        do_reset();
        tb_rr = 1'b1;
        tb_v = 4'b0001; step();
        tb_v = 4'b0010; step();
        tb_v = 4'b1001; step();
        chk("t4_g3", 32'(act_ready), 32'b1000);
        chk("t4_id3", 32'(rsp_id), 32'd3);
        step();
        chk("t4_g0", 32'(act_ready), 32'b0001);
        chk("t4_id0", 32'(rsp_id), 32'd0);

        // asynchronous reset while holding
        tb_v = '0; tb_rr = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("t5_valid", 32'(rsp_valid), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_data", 32'(rsp_data), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tb_v = 4'b1111; tb_rr = 1'b1;
        step();
        chk("t5_prio", 32'(act_ready), 32'b0001);

        if (OPSEL) begin
            do_reset();
            tb_v = 4'b0001; tb_rr = 1'b1;
            tb_a[0 +: W] = 3'b110; tb_b[0 +: W] = 3'b011;
            for (int k = 0; k < 4; k++) begin
                tb_op[1:0] = ops[k];
                step();
                chk("t6_data", 32'(rsp_data), 32'(op_res[k]));
                chk("t6_op", 32'(rsp_op), 32'(ops[k]));
            end
        end

        // randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tb_v  = N'($urandom);
            tb_a  = (N*W)'($urandom);
            tb_b  = (N*W)'($urandom);
            tb_op = (N*2)'($urandom);
            tb_rr = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) tb_v = '0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
